// File: rtl/pulse_to_level_if.sv
// Event-pulse in / reconstructed-level out bundle for pulse_to_level.
// The master modport is the pulse source; the slave modport is the converter.
interface pulse_to_level_if #(
  parameter int CNT_W = 3
);
  logic             pi;
  logic             lo;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  modport master (output pi, input lo, busy, pending, overflow);
  modport slave  (input pi, output lo, busy, pending, overflow);
endinterface

// File: rtl/pulse_to_level.sv
// Replays each accepted single-cycle event pulse as a HOLD_CYCLES-wide high window,
// followed by a GAP_CYCLES low gap. Pulses arriving mid-replay queue in a saturating counter.
module pulse_to_level #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 3
) (
  input  logic            clk,
  input  logic            rst,
  pulse_to_level_if.slave bus
);
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CYC_W-1:0] HOLD_LOAD = CYC_W'(HOLD_CYCLES - 1);
  localparam logic [CYC_W-1:0] GAP_LOAD  = CYC_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CYC_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_pending, w_pending_nxt;
  logic             r_lo, w_lo_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             w_pi, w_cnt_zero, w_start, w_enqueue;

  assign w_pi       = bus.pi;
  assign w_cnt_zero = (r_cnt == '0);
  // A window may begin from IDLE or on the final GAP edge, so back-to-back windows keep the exact gap.
  assign w_start    = ((r_state == IDLE) || ((r_state == GAP) && w_cnt_zero)) &&
                      (w_pi || (r_pending != '0));
  assign w_enqueue  = w_pi && ((r_state == HIGH) || ((r_state == GAP) && !w_cnt_zero));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_lo       <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_lo       <= w_lo_nxt;
      r_busy     <= w_busy_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_start) begin
      w_state_nxt = HIGH;
      w_cnt_nxt   = HOLD_LOAD;
    end else begin
      case (r_state)
        HIGH: begin
          if (w_cnt_zero) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (w_cnt_zero) w_state_nxt = IDLE;
          else            w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_lo_nxt       = (w_state_nxt == HIGH);
    w_busy_nxt     = (w_state_nxt != IDLE);
    w_pending_nxt  = r_pending;
    w_overflow_nxt = 1'b0;
    // On a start with pi high and a non-empty queue, consume and enqueue cancel out.
    if (w_start) begin
      if ((r_pending != '0) && !w_pi) w_pending_nxt = r_pending - 1'b1;
    end else if (w_enqueue) begin
      if (r_pending == PEND_MAX) w_overflow_nxt = 1'b1;
      else                       w_pending_nxt  = r_pending + 1'b1;
    end
  end

  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;
endmodule
